// File: rtl/fruit_slice_ctrl_if.sv
// ----------------------------------------------------------------------------
// fruit_slice_ctrl_if
// Purpose : groups the game-flow signals between the fruit/blade front end
//           and the slice controller.
// Signals : game_en, fruitX/Y/S, bladeX/Y, blade_down   (into controller)
//           new_fruit, move_fruit, sliced, missed,
//           number_of_fruits_cut, lives, game_over       (out of controller)
//           combo                                        (FRUIT_COMBO_EN only)
// Modports: master = driver of game inputs / observer of results
//           slave  = the controller itself
// Config  : FRUIT_COMBO_EN adds the 4-bit combo result signal.
// ----------------------------------------------------------------------------
interface fruit_slice_ctrl_if;
    logic       game_en;
    logic [9:0] fruitX;
    logic [9:0] fruitY;
    logic [9:0] fruitS;
    logic [9:0] bladeX;
    logic [9:0] bladeY;
    logic       blade_down;
    logic       new_fruit;
    logic       move_fruit;
    logic       sliced;
    logic       missed;
    logic [7:0] number_of_fruits_cut;
    logic [1:0] lives;
    logic       game_over;
`ifdef FRUIT_COMBO_EN
    logic [3:0] combo;
`endif

    modport master (
        output game_en, fruitX, fruitY, fruitS, bladeX, bladeY, blade_down,
        input  new_fruit, move_fruit, sliced, missed, number_of_fruits_cut,
               lives, game_over
`ifdef FRUIT_COMBO_EN
        , input combo
`endif
    );

    modport slave (
        input  game_en, fruitX, fruitY, fruitS, bladeX, bladeY, blade_down,
        output new_fruit, move_fruit, sliced, missed, number_of_fruits_cut,
               lives, game_over
`ifdef FRUIT_COMBO_EN
        , output combo
`endif
    );
endinterface

// File: rtl/fruit_slice_ctrl.sv
// ----------------------------------------------------------------------------
// fruit_slice_ctrl
// Purpose : game-flow controller behind the fruit motion block. Spawns a
//           fruit, lets it fly, confirms blade slices over several frames,
//           detects fruits leaving the screen, and tracks score, lives and
//           game over.
// Ports   : frame_clk  - frame-rate clock, all state on rising edge
//           Reset      - asynchronous, active-low
//           bus        - fruit_slice_ctrl_if.slave (game inputs / results)
// Config  : define FRUIT_COMBO_EN to add the combo counter; a slice that
//           brings combo to COMBO_N or more scores 2 instead of 1.
// ----------------------------------------------------------------------------
module fruit_slice_ctrl #(
    parameter int unsigned LIVES       = 3,
    parameter int unsigned HIT_CONFIRM = 2,
    parameter int unsigned ARM_FRAMES  = 2,
    parameter int unsigned HOLD_FRAMES = 8,
    parameter int unsigned MISS_Y      = 479,
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned COMBO_N     = 4
) (
    input  logic               frame_clk,
    input  logic               Reset,
    fruit_slice_ctrl_if.slave  bus
);

    localparam logic [1:0] LIVES_C   = 2'(LIVES);
    localparam logic [2:0] HIT_C     = 3'(HIT_CONFIRM);
    localparam logic [3:0] ARM_LAST  = 4'(ARM_FRAMES - 1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_FRAMES - 1);
    localparam logic [9:0] MISS_Y_C  = 10'(MISS_Y);
    localparam logic [9:0] X_MAX_C   = 10'(X_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_ARM, S_FLIGHT, S_HIT, S_MISS, S_OVER
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tmr_q, tmr_d;
    logic [2:0] hit_q, hit_d;
    logic [7:0] count_q, count_d;
    logic [1:0] lives_q, lives_d;
    logic       new_fruit_q, new_fruit_d;
    logic       move_q, move_d;
    logic       sliced_q, sliced_d;
    logic       missed_q, missed_d;
    logic       over_q, over_d;

    // Blade/fruit overlap on 11-bit signed differences so that a blade left
    // of or above the fruit compares correctly.
    logic signed [10:0] dx, dy;
    logic        [10:0] adx, ady;
    logic               overlap;
    logic               miss_cond;
    logic        [2:0]  hit_inc;
    logic               confirm;

    assign dx        = $signed({1'b0, bus.bladeX}) - $signed({1'b0, bus.fruitX});
    assign dy        = $signed({1'b0, bus.bladeY}) - $signed({1'b0, bus.fruitY});
    assign adx       = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    assign ady       = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    assign overlap   = bus.blade_down
                     & (adx <= {1'b0, bus.fruitS})
                     & (ady <= {1'b0, bus.fruitS});
    // Negative positions wrap to large unsigned values, so the same
    // greater-than test also catches fruits leaving at the top/left.
    assign miss_cond = (bus.fruitY > MISS_Y_C) | (bus.fruitX > X_MAX_C);
    assign hit_inc   = (hit_q == 3'd7) ? hit_q : hit_q + 3'd1;
    assign confirm   = overlap & (hit_inc == HIT_C);

    // Score increment for a confirmed slice.
    logic [1:0] slice_add;
    logic [8:0] count_sum;
    logic [7:0] count_sat;
    logic [1:0] lives_dec;

`ifdef FRUIT_COMBO_EN
    localparam logic [4:0] COMBO_C = 5'(COMBO_N);
    logic [3:0] combo_q, combo_d;
    logic [3:0] combo_inc;

    // Threshold uses the combo value including the slice being scored.
    assign combo_inc = (combo_q == 4'hF) ? combo_q : combo_q + 4'd1;
    assign slice_add = ({1'b0, combo_inc} >= COMBO_C) ? 2'd2 : 2'd1;
    assign bus.combo = combo_q;
`else
    assign slice_add = 2'd1;
`endif

    assign count_sum = {1'b0, count_q} + {7'd0, slice_add};
    assign count_sat = count_sum[8] ? 8'hFF : count_sum[7:0];
    assign lives_dec = (lives_q == '0) ? '0 : lives_q - 2'd1;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        hit_d       = '0;
        count_d     = count_q;
        lives_d     = lives_q;
        new_fruit_d = 1'b0;
        move_d      = 1'b0;
        sliced_d    = 1'b0;
        missed_d    = 1'b0;
        over_d      = 1'b0;
`ifdef FRUIT_COMBO_EN
        combo_d     = combo_q;
`endif
        if (!bus.game_en) begin
            state_d = S_IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SPAWN;
                    tmr_d   = '0;
                    count_d = '0;
                    lives_d = LIVES_C;
`ifdef FRUIT_COMBO_EN
                    combo_d = '0;
`endif
                end
                S_SPAWN: begin
                    new_fruit_d = 1'b1;
                    state_d     = S_ARM;
                    tmr_d       = '0;
                end
                S_ARM: begin
                    move_d = 1'b1;
                    if (tmr_q == ARM_LAST) begin
                        state_d = S_FLIGHT;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 4'd1;
                    end
                end
                S_FLIGHT: begin
                    move_d = 1'b1;
                    if (overlap) hit_d = hit_inc;
                    // A confirmed slice takes priority over a miss.
                    if (confirm) begin
                        state_d = S_HIT;
                        hit_d   = '0;
                        tmr_d   = '0;
                    end else if (miss_cond) begin
                        state_d = S_MISS;
                        hit_d   = '0;
                        tmr_d   = '0;
                    end
                end
                S_HIT: begin
                    // Pulse and score land on the first HIT cycle so they
                    // appear one cycle after the state entry.
                    if (tmr_q == '0) begin
                        sliced_d = 1'b1;
                        count_d  = count_sat;
`ifdef FRUIT_COMBO_EN
                        combo_d  = combo_inc;
`endif
                    end
                    if (tmr_q == HOLD_LAST) begin
                        state_d = S_SPAWN;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 4'd1;
                    end
                end
                S_MISS: begin
                    if (tmr_q == '0) begin
                        missed_d = 1'b1;
                        lives_d  = lives_dec;
`ifdef FRUIT_COMBO_EN
                        combo_d  = '0;
`endif
                    end
                    if (tmr_q == HOLD_LAST) begin
                        // lives_d already reflects this miss's decrement.
                        state_d = (lives_d == '0) ? S_OVER : S_SPAWN;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 4'd1;
                    end
                end
                S_OVER: begin
                    over_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            hit_q       <= '0;
            count_q     <= '0;
            lives_q     <= LIVES_C;
            new_fruit_q <= 1'b0;
            move_q      <= 1'b0;
            sliced_q    <= 1'b0;
            missed_q    <= 1'b0;
            over_q      <= 1'b0;
`ifdef FRUIT_COMBO_EN
            combo_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            hit_q       <= hit_d;
            count_q     <= count_d;
            lives_q     <= lives_d;
            new_fruit_q <= new_fruit_d;
            move_q      <= move_d;
            sliced_q    <= sliced_d;
            missed_q    <= missed_d;
            over_q      <= over_d;
`ifdef FRUIT_COMBO_EN
            combo_q     <= combo_d;
`endif
        end
    end

    assign bus.new_fruit            = new_fruit_q;
    assign bus.move_fruit           = move_q;
    assign bus.sliced               = sliced_q;
    assign bus.missed               = missed_q;
    assign bus.number_of_fruits_cut = count_q;
    assign bus.lives                = lives_q;
    assign bus.game_over            = over_q;

endmodule
